// File: rtl/adc_cap_pkg.sv
// Shared types and constants for the ADC sample capture block.
package adc_cap_pkg;

  localparam int unsigned DEF_CLK_DIV       = 4;
  localparam int unsigned DEF_SAMPLE_BITS   = 16;
  localparam int unsigned DEF_SAMPLE_PERIOD = 200;
  localparam int unsigned SAMPLE_W          = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } cap_state_e;

  // Shortest trigger period that still lets every frame finish before the next trigger.
  function automatic int unsigned min_sample_period(input int unsigned clk_div,
                                                    input int unsigned sample_bits);
    return clk_div * (2 * sample_bits + 1) + 2;
  endfunction

endpackage

// File: rtl/sclk_gen.sv
// Serial clock divider: toggles sclk every CLK_DIV cycles while run_i is high.
// rise_c/fall_c flag the cycle at whose closing edge sclk goes high/low.
module sclk_gen
  import adc_cap_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic sclk_o,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          tick;

  always_comb begin
    tick   = 1'b0;
    cnt_d  = '0;
    sclk_d = 1'b0;
    rise_c = 1'b0;
    fall_c = 1'b0;
    if (run_i) begin
      tick   = (cnt_q == CW'(CLK_DIV - 1));
      cnt_d  = tick ? '0 : cnt_q + CW'(1);
      sclk_d = tick ? ~sclk_q : sclk_q;
      rise_c = tick && !sclk_q;
      fall_c = tick && sclk_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/adc_sample_capture.sv
// Periodic SPI-style ADC reader: triggers every SAMPLE_PERIOD cycles, shifts in
// SAMPLE_BITS MSB first and presents the result with a one-cycle ready pulse.
module adc_sample_capture
  import adc_cap_pkg::*;
#(
  parameter int unsigned CLK_DIV       = DEF_CLK_DIV,
  parameter int unsigned SAMPLE_BITS   = DEF_SAMPLE_BITS,
  parameter int unsigned SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  input  logic                adc_miso,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_ready,
  output logic                overrun
);

  localparam int unsigned PW = $clog2(SAMPLE_PERIOD + 1);
  localparam int unsigned SW = $clog2(CLK_DIV + 1);
  localparam int unsigned BW = $clog2(SAMPLE_BITS + 1);

  cap_state_e             state_q, state_d;
  logic [PW-1:0]          per_q, per_d;
  logic [SW-1:0]          setup_q, setup_d;
  logic [BW-1:0]          bits_q, bits_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0]    sample_q, sample_d;
  logic                   ready_q, ready_d;
  logic                   overrun_q, overrun_d;
  logic                   cs_n_q, cs_n_d;
  logic                   trigger;
  logic                   run;
  logic                   rise_c, fall_c;

  assign run = (state_q == ST_SHIFT);

  sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .rst    (rst),
    .run_i  (run),
    .sclk_o (adc_sclk),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    setup_d   = setup_q;
    bits_d    = bits_q;
    shift_d   = shift_q;
    sample_d  = sample_q;
    ready_d   = 1'b0;
    overrun_d = overrun_q;

    trigger = en && (per_q == PW'(SAMPLE_PERIOD - 1));

    if (!en || trigger) per_d = '0;
    else                per_d = per_q + PW'(1);

    // A trigger that lands on a busy frame is lost; remember that it happened.
    if (trigger && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_SETUP;
          setup_d = '0;
        end
      end
      ST_SETUP: begin
        if (setup_q == SW'(CLK_DIV - 1)) begin
          state_d = ST_SHIFT;
          bits_d  = '0;
        end else begin
          setup_d = setup_q + SW'(1);
        end
      end
      ST_SHIFT: begin
        if (rise_c) begin
          shift_d = SAMPLE_BITS'({shift_q, adc_miso});
          bits_d  = bits_q + BW'(1);
        end
        // The frame ends on the falling edge that closes the last sclk period.
        if (fall_c && (bits_q == BW'(SAMPLE_BITS))) begin
          state_d  = ST_DONE;
          sample_d = SAMPLE_W'(shift_q);
          ready_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cs_n_d = !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      per_q     <= '0;
      setup_q   <= '0;
      bits_q    <= '0;
      shift_q   <= '0;
      sample_q  <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      setup_q   <= setup_d;
      bits_q    <= bits_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign sample       = sample_q;
  assign sample_ready = ready_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed bench for adc_sample_capture with a serial ADC model and a second
// instance run with a too-short trigger period.
module tb_adc_sample_capture;

  localparam int unsigned CD = 2;
  localparam int unsigned SB = 8;
  localparam int unsigned SP = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        adc_cs_n, adc_sclk;
  logic        adc_miso = 1'b0;
  logic [31:0] sample;
  logic        sample_ready, overrun;

  logic        rst2 = 1'b1;
  logic        en2  = 1'b0;
  logic        cs_n2, sclk2;
  logic        miso2 = 1'b1;
  logic [31:0] sample2;
  logic        ready2, overrun2;

  logic [7:0]  adc_word = 8'h00;
  int          bit_idx = 7;
  logic        sclk_prev = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_sample_capture #(
    .CLK_DIV (CD), .SAMPLE_BITS (SB), .SAMPLE_PERIOD (SP)
  ) u_dut (
    .clk (clk), .rst (rst), .en (en),
    .adc_cs_n (adc_cs_n), .adc_sclk (adc_sclk), .adc_miso (adc_miso),
    .sample (sample), .sample_ready (sample_ready), .overrun (overrun)
  );

  adc_sample_capture #(
    .CLK_DIV (CD), .SAMPLE_BITS (SB), .SAMPLE_PERIOD (20)
  ) u_ovr (
    .clk (clk), .rst (rst2), .en (en2),
    .adc_cs_n (cs_n2), .adc_sclk (sclk2), .adc_miso (miso2),
    .sample (sample2), .sample_ready (ready2), .overrun (overrun2)
  );

  // ADC model: MSB presented while cs_n falls, next bit after each sclk fall.
  always @(negedge clk) begin
    if (adc_cs_n) bit_idx = 7;
    else if (sclk_prev && !adc_sclk && bit_idx > 0) bit_idx = bit_idx - 1;
    sclk_prev = adc_sclk;
    adc_miso  = adc_word[bit_idx];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic watch(input int max_cyc, output int cs_at, output int rdy_at,
                       output int rdy_len, output logic [31:0] rdy_val);
    cs_at = -1; rdy_at = -1; rdy_len = 0; rdy_val = '0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!adc_cs_n && cs_at < 0) cs_at = cyc;
      if (sample_ready) begin
        if (rdy_at < 0) begin
          rdy_at  = cyc;
          rdy_val = sample;
        end
        rdy_len++;
      end else if (rdy_at >= 0) begin
        break;
      end
    end
  endtask

  task automatic wait_cs_low(input int max_cyc, output logic found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!adc_cs_n) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int          c0, cs_at, rdy_at, rdy_len, prev_rdy, quiet_cs, quiet_rdy, sum;
    logic [31:0] val;
    logic        found, ovr_before, ovr_after;
    logic [7:0]  words [3];
    int          ovr_rdy [$];
    logic [31:0] ovr_val [$];

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(adc_cs_n), 32'h1);
    chk("rst_sclk", 32'(adc_sclk), 32'h0);
    chk("rst_sample", sample, 32'h0);
    chk("rst_ready", 32'(sample_ready), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);

    // First frame: 0xA5, trigger at c0+39, cs_n low c0+40, ready c0+74
    adc_word = 8'hA5;
    rst = 1'b0;
    en  = 1'b1;
    c0  = cyc;
    watch(100, cs_at, rdy_at, rdy_len, val);
    chk("a5_cs_time", 32'(cs_at - c0), 32'd40);
    chk("a5_rdy_time", 32'(rdy_at - c0), 32'd74);
    chk("a5_sample", val, 32'h0000_00A5);
    chk("a5_rdy_len", 32'(rdy_len), 32'd1);

    // Back-to-back frames, ready pulses SP apart
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    prev_rdy = rdy_at;
    for (int k = 0; k < 3; k++) begin
      adc_word = words[k];
      watch(60, cs_at, rdy_at, rdy_len, val);
      chk($sformatf("seq%0d_period", k), 32'(rdy_at - prev_rdy), 32'd40);
      chk($sformatf("seq%0d_sample", k), val, 32'(words[k]));
      prev_rdy = rdy_at;
    end
    chk("seq_overrun", 32'(overrun), 32'h0);

    // en dropped in SETUP: frame finishes, then the bus stays quiet
    adc_word = 8'h3C;
    wait_cs_low(60, found);
    chk("endrop_cs_found", 32'(found), 32'h1);
    en = 1'b0;
    watch(60, cs_at, rdy_at, rdy_len, val);
    chk("endrop_sample", val, 32'h0000_003C);
    chk("endrop_rdy_len", 32'(rdy_len), 32'd1);
    quiet_cs = 0; quiet_rdy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!adc_cs_n) quiet_cs++;
      if (sample_ready) quiet_rdy++;
    end
    chk("endrop_quiet_cs", 32'(quiet_cs), 32'd0);
    chk("endrop_quiet_rdy", 32'(quiet_rdy), 32'd0);

    // Re-enable: first trigger SP-1 cycles after en rises
    adc_word = 8'h5A;
    en = 1'b1;
    c0 = cyc;
    watch(100, cs_at, rdy_at, rdy_len, val);
    chk("reen_cs_time", 32'(cs_at - c0), 32'd40);
    chk("reen_rdy_time", 32'(rdy_at - c0), 32'd74);
    chk("reen_sample", val, 32'h0000_005A);

    // Reset in the middle of SHIFT while sclk is high
    adc_word = 8'hC3;
    wait_cs_low(60, found);
    chk("rstmid_cs_found", 32'(found), 32'h1);
    repeat (5) @(negedge clk);
    chk("rstmid_pre_sclk", 32'(adc_sclk), 32'h1);
    chk("rstmid_pre_sample", sample, 32'h0000_005A);
    rst = 1'b1;
    #1;
    chk("rstmid_cs_n", 32'(adc_cs_n), 32'h1);
    chk("rstmid_sclk", 32'(adc_sclk), 32'h0);
    chk("rstmid_sample", sample, 32'h0);
    chk("rstmid_ready", 32'(sample_ready), 32'h0);
    chk("rstmid_overrun", 32'(overrun), 32'h0);
    quiet_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (sample_ready) quiet_rdy++;
    end
    chk("rstmid_no_ready", 32'(quiet_rdy), 32'd0);

    // Constant input 7 over several frames averages to 7
    en  = 1'b0;
    rst = 1'b0;
    adc_word = 8'd7;
    @(negedge clk);
    en = 1'b1;
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      watch(100, cs_at, rdy_at, rdy_len, val);
      sum = sum + int'(val);
    end
    chk("avg_const7", 32'(sum / 4), 32'd7);

    // Period below minimum: every second trigger is lost and overrun sticks
    rst2 = 1'b0;
    en2  = 1'b1;
    c0   = cyc;
    ovr_before = 1'b1; ovr_after = 1'b0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (cyc - c0 == 39) ovr_before = overrun2;
      if (cyc - c0 == 40) ovr_after  = overrun2;
      if (ready2) begin
        ovr_rdy.push_back(cyc - c0);
        ovr_val.push_back(sample2);
      end
    end
    chk("ovr_before_2nd", 32'(ovr_before), 32'h0);
    chk("ovr_after_2nd", 32'(ovr_after), 32'h1);
    chk("ovr_sticky", 32'(overrun2), 32'h1);
    chk("ovr_rdy_count", 32'(ovr_rdy.size()), 32'd3);
    if (ovr_rdy.size() == 3) begin
      chk("ovr_rdy0", 32'(ovr_rdy[0]), 32'd54);
      chk("ovr_rdy1", 32'(ovr_rdy[1]), 32'd94);
      chk("ovr_rdy2", 32'(ovr_rdy[2]), 32'd134);
      chk("ovr_sample", ovr_val[0], 32'h0000_00FF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_sample_capture.md
ADC_SAMPLE_CAPTURE -- requirements
Module: adc_sample_capture

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per adc_sclk half-period, minimum 1.
REQ-002 Parameter SAMPLE_BITS, default 16: bits per ADC conversion, range 1..32.
REQ-003 Parameter SAMPLE_PERIOD, default 200: clk cycles between conversion triggers; SHALL satisfy SAMPLE_PERIOD >= CLK_DIV*(2*SAMPLE_BITS+1)+2.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 en  input  1  enables periodic triggering.
REQ-008 adc_cs_n  output  1  ADC chip select, active low.
REQ-009 adc_sclk  output  1  ADC serial clock, idle low.
REQ-010 adc_miso  input  1  ADC serial data, MSB first.
REQ-011 sample  output  32  last captured conversion, zero-extended.
REQ-012 sample_ready  output  1  one-cycle pulse; sample is valid in that cycle; feeds the downstream averager's sample_ready.
REQ-013 overrun  output  1  sticky flag; trigger arrived while a frame was in progress.

Function
REQ-014 Period counter SHALL count 0..SAMPLE_PERIOD-1 while en=1, wrap to 0, and be held at 0 while en=0.
REQ-015 Trigger SHALL occur in the cycle where en=1 and counter=SAMPLE_PERIOD-1.
REQ-016 FSM states IDLE, SETUP, SHIFT, DONE; IDLE->SETUP on trigger; SETUP->SHIFT after CLK_DIV cycles; SHIFT->DONE after SAMPLE_BITS full sclk periods; DONE->IDLE unconditionally after 1 cycle.
REQ-017 IDLE: adc_cs_n=1, adc_sclk=0. SETUP/SHIFT: adc_cs_n=0. DONE: adc_cs_n=1.
REQ-018 SHIFT: adc_sclk starts low, toggles every CLK_DIV cycles, ends low; adc_miso is sampled on the clk cycle in which adc_sclk goes high, shifted in MSB first.
REQ-019 DONE: sample <= shift register zero-extended to 32 bits; sample_ready=1 for exactly that cycle; sample holds its value until the next DONE.
REQ-020 Latency: trigger in cycle T -> adc_cs_n low from T+1 -> sample_ready high in cycle T+1+CLK_DIV*(2*SAMPLE_BITS+1).
REQ-021 Trigger while FSM not in IDLE SHALL be dropped and SHALL set overrun=1; overrun clears only on rst.
REQ-022 en deasserted mid-frame: current frame SHALL complete, including the sample_ready pulse; no new trigger until en=1 and the counter wraps again.
REQ-023 en reasserted: first trigger SHALL occur SAMPLE_PERIOD-1 cycles after the first cycle with en=1.

Reset
REQ-024 rst=1 SHALL immediately force: state IDLE, counter 0, adc_cs_n=1, adc_sclk=0, sample=0, sample_ready=0, overrun=0, shift register 0.
REQ-025 rst mid-frame SHALL abort the frame with no sample_ready pulse; the ADC sees adc_cs_n rise asynchronously.

Structure
REQ-026 Shared package adc_cap_pkg SHALL hold the FSM state enum, default parameter constants, and the minimum-period expression.
REQ-027 Sub-module sclk_gen SHALL contain the CLK_DIV divider, producing adc_sclk plus one-cycle rise/fall strobes, enabled only in SHIFT.
REQ-028 Target size 120-400 RTL lines; no combinational path from adc_miso to any output.

Verification (CLK_DIV=2, SAMPLE_BITS=8, SAMPLE_PERIOD=40 unless noted)
REQ-029 Reset then en=1, ADC model drives 0xA5 -> sample=0x000000A5, sample_ready pulse 1 cycle wide, 35 cycles after trigger (T+1+2*17).
REQ-030 en=1 continuously, ADC model drives 0x01, 0x80, 0xFF -> sample_ready pulses exactly 40 cycles apart, samples 0x01, 0x80, 0xFF, overrun=0.
REQ-031 SAMPLE_PERIOD=20 (below minimum) -> every second trigger dropped, overrun=1 after the second trigger.
REQ-032 rst pulsed midway through SHIFT -> adc_cs_n=1 and all outputs at reset values in the same cycle; no sample_ready pulse.
REQ-033 en dropped during SETUP -> frame completes with a sample_ready pulse; no further adc_cs_n activity while en=0.
REQ-034 End-to-end with downstream accum_and_avg: constant ADC value 7 -> averager avg converges to 7.
